// File: rtl/bp_pkg.sv
// Shared constants and types for the BTB-based branch predictor.
package bp_pkg;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  localparam int PM_STATIC  = 0;
  localparam int PM_BIMODAL = 1;

  // Reference entry layout for the default geometry (32-bit PC, 16 entries, 2-bit counter).
  localparam int BP_ADDR_W = 32;
  localparam int BP_IDX_W  = 4;
  localparam int BP_TAG_W  = BP_ADDR_W - BP_IDX_W - 2;
  localparam int BP_CNT_W  = 2;

  typedef struct packed {
    logic                 valid;
    logic [BP_TAG_W-1:0]  tag;
    logic [BP_ADDR_W-1:0] target;
    logic [BP_CNT_W-1:0]  cnt;
  } bp_entry_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup, EX-side resolution and statistics signals of the branch predictor.
interface branch_predictor_if #(
  parameter int ADDR_W = 32,
  parameter int STAT_W = 16
);
  logic [ADDR_W-1:0] If_Pc;
  logic              Pred_Taken;
  logic [ADDR_W-1:0] Pred_Addr;
  logic              Ex_Br;
  logic [ADDR_W-1:0] Ex_Pc;
  logic              Ex_Taken;
  logic [ADDR_W-1:0] Ex_Target;
  logic              Ex_Pred_Taken;
  logic [ADDR_W-1:0] Ex_Pred_Addr;
  logic              Mispredict;
  logic [ADDR_W-1:0] Redirect_Addr;
  logic [STAT_W-1:0] Br_Count;
  logic [STAT_W-1:0] Miss_Count;

  modport master (
    output If_Pc, Ex_Br, Ex_Pc, Ex_Taken, Ex_Target, Ex_Pred_Taken, Ex_Pred_Addr,
    input  Pred_Taken, Pred_Addr, Mispredict, Redirect_Addr, Br_Count, Miss_Count
  );

  modport slave (
    input  If_Pc, Ex_Br, Ex_Pc, Ex_Taken, Ex_Target, Ex_Pred_Taken, Ex_Pred_Addr,
    output Pred_Taken, Pred_Addr, Mispredict, Redirect_Addr, Br_Count, Miss_Count
  );
endinterface

// File: rtl/bp_sat_counter.sv
// Saturating up/down counter with parallel load; resets to weakly not-taken.
module bp_sat_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                         cnt_d = load_val;
    else if (inc && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    else if (dec && cnt_q != '0)      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= CNT_RST;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters: same-cycle prediction at IF,
// training and mispredict detection at EX, plus saturating branch/miss statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int ENTRIES   = 16,
  parameter int CNT_W     = 2,
  parameter int PRED_MODE = 1,
  parameter int STAT_W    = 16
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              EN,
  branch_predictor_if.slave bus
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX - 2;
  localparam bit DYN   = (PRED_MODE == PM_BIMODAL);
  localparam logic [CNT_W-1:0] CNT_WT = CNT_W'(1 << (CNT_W - 1));

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_d [ENTRIES];
  logic [CNT_W-1:0]   cnt   [ENTRIES];
  logic [ENTRIES-1:0] cnt_inc, cnt_dec, cnt_load;
  logic [STAT_W-1:0]  br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [IDX-1:0]   rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_hit, wr_hit, pred_taken, mispredict, upd;
  logic [1:0]       unused_pc_lsb;

  assign unused_pc_lsb = bus.If_Pc[1:0] ^ bus.Ex_Pc[1:0];

  assign rd_idx = bus.If_Pc[IDX+1:2];
  assign rd_tag = bus.If_Pc[ADDR_W-1:IDX+2];
  assign wr_idx = bus.Ex_Pc[IDX+1:2];
  assign wr_tag = bus.Ex_Pc[ADDR_W-1:IDX+2];

  // Lookup reads the registered table, so a same-cycle update is seen one cycle later.
  assign rd_hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign wr_hit     = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  assign pred_taken = DYN && rd_hit && cnt[rd_idx][CNT_W-1];

  assign bus.Pred_Taken = pred_taken;
  assign bus.Pred_Addr  = pred_taken ? tgt_q[rd_idx] : bus.If_Pc + ADDR_W'(4);

  assign mispredict = bus.Ex_Br &&
                      ((bus.Ex_Taken != bus.Ex_Pred_Taken) ||
                       (bus.Ex_Taken && (bus.Ex_Target != bus.Ex_Pred_Addr)));

  assign bus.Mispredict    = mispredict;
  assign bus.Redirect_Addr = bus.Ex_Taken ? bus.Ex_Target : bus.Ex_Pc + ADDR_W'(4);
  assign bus.Br_Count      = br_cnt_q;
  assign bus.Miss_Count    = miss_cnt_q;

  assign upd = EN && bus.Ex_Br && DYN;

  // Hits train the counter; only taken misses allocate, evicting any aliased entry.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    tgt_d    = tgt_q;
    cnt_inc  = '0;
    cnt_dec  = '0;
    cnt_load = '0;
    if (upd) begin
      if (wr_hit) begin
        cnt_inc[wr_idx] = bus.Ex_Taken;
        cnt_dec[wr_idx] = !bus.Ex_Taken;
        if (bus.Ex_Taken) tgt_d[wr_idx] = bus.Ex_Target;
      end else if (bus.Ex_Taken) begin
        valid_d[wr_idx]  = 1'b1;
        tag_d[wr_idx]    = wr_tag;
        tgt_d[wr_idx]    = bus.Ex_Target;
        cnt_load[wr_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (EN && bus.Ex_Br) begin
      if (br_cnt_q != '1)                 br_cnt_d   = br_cnt_q + STAT_W'(1);
      if (mispredict && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      valid_q    <= '0;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else if (EN) begin
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      tgt_q      <= tgt_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_cnt
    bp_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (CLK),
      .rst_n    (CLR_N),
      .inc      (cnt_inc[g]),
      .dec      (cnt_dec[g]),
      .load     (cnt_load[g]),
      .load_val (CNT_WT),
      .cnt      (cnt[g])
    );
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a dynamic instance checked against an array-based model,
// and a static-mode instance with narrow statistics counters for saturation.
module tb_branch_predictor;

  logic CLK = 1'b0;
  logic CLR_N;
  logic EN;

  always #5 CLK = ~CLK;

  branch_predictor_if #(.ADDR_W(32), .STAT_W(16)) bus ();
  branch_predictor_if #(.ADDR_W(32), .STAT_W(8))  bus2 ();

  branch_predictor #(.ADDR_W(32), .ENTRIES(16), .CNT_W(2), .PRED_MODE(1), .STAT_W(16)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .EN(EN), .bus(bus.slave)
  );

  branch_predictor #(.ADDR_W(32), .ENTRIES(16), .CNT_W(2), .PRED_MODE(0), .STAT_W(8)) dut2 (
    .CLK(CLK), .CLR_N(CLR_N), .EN(EN), .bus(bus2.slave)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: 16 entries indexed by (pc/4)%16, tag = pc/64, counter 0..3.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_cnt   [16];
  int          m_br, m_miss;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
    end
    m_br = 0; m_miss = 0;
  endfunction

  function automatic void model_lookup(input logic [31:0] pc, output bit t, output logic [31:0] a);
    int idx = int'((pc / 4) % 16);
    t = m_valid[idx] && (m_tag[idx] == pc / 64) && (m_cnt[idx] >= 2);
    a = t ? m_tgt[idx] : pc + 32'd4;
  endfunction

  function automatic bit model_mis(input bit br, input bit tk, input bit ptk,
                                   input logic [31:0] tgt, input logic [31:0] paddr);
    if (!br) return 0;
    if (tk != ptk) return 1;
    return tk && (tgt != paddr);
  endfunction

  function automatic void model_update(input bit en, input bit br, input logic [31:0] pc,
                                       input bit tk, input logic [31:0] tgt, input bit mis);
    int idx;
    if (!en || !br) return;
    if (m_br < 65535) m_br++;
    if (mis && m_miss < 65535) m_miss++;
    idx = int'((pc / 4) % 16);
    if (m_valid[idx] && m_tag[idx] == pc / 64) begin
      if (tk) begin
        if (m_cnt[idx] < 3) m_cnt[idx]++;
        m_tgt[idx] = tgt;
      end else if (m_cnt[idx] > 0) m_cnt[idx]--;
    end else if (tk) begin
      m_valid[idx] = 1; m_tag[idx] = pc / 64; m_tgt[idx] = tgt; m_cnt[idx] = 2;
    end
  endfunction

  task automatic drive(input logic [31:0] ifpc, input bit br, input logic [31:0] expc,
                       input bit tk, input logic [31:0] tgt, input bit ptk,
                       input logic [31:0] paddr, input bit en);
    @(negedge CLK);
    EN = en;
    bus.If_Pc = ifpc; bus.Ex_Br = br; bus.Ex_Pc = expc; bus.Ex_Taken = tk;
    bus.Ex_Target = tgt; bus.Ex_Pred_Taken = ptk; bus.Ex_Pred_Addr = paddr;
    #1;
  endtask

  task automatic tick();
    bit mis;
    @(posedge CLK);
    mis = model_mis(bus.Ex_Br, bus.Ex_Taken, bus.Ex_Pred_Taken, bus.Ex_Target, bus.Ex_Pred_Addr);
    model_update(EN, bus.Ex_Br, bus.Ex_Pc, bus.Ex_Taken, bus.Ex_Target, mis);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    CLR_N = 1'b0;
    bus.Ex_Br = 1'b0; bus2.Ex_Br = 1'b0;
    model_reset();
    @(negedge CLK);
    CLR_N = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    checks++; if (bus.Pred_Taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got %b exp 0", bus.Pred_Taken); end
    checks++; if (bus.Pred_Addr !== 32'h44) begin errors++; $display("FAIL reset_pred_addr got %h exp 00000044", bus.Pred_Addr); end
    checks++; if (bus.Br_Count !== 16'd0) begin errors++; $display("FAIL reset_br_count got %0d exp 0", bus.Br_Count); end
    checks++; if (bus.Miss_Count !== 16'd0) begin errors++; $display("FAIL reset_miss_count got %0d exp 0", bus.Miss_Count); end
    checks++; if (bus.Mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict got %b exp 0", bus.Mispredict); end
    checks++; if (bus2.Br_Count !== 8'd0) begin errors++; $display("FAIL reset_static_br got %0d exp 0", bus2.Br_Count); end
  endtask

  task automatic test_allocate();
    drive(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 1);
    checks++; if (bus.Mispredict !== 1'b1) begin errors++; $display("FAIL alloc_mispredict got %b exp 1", bus.Mispredict); end
    checks++; if (bus.Redirect_Addr !== 32'h100) begin errors++; $display("FAIL alloc_redirect got %h exp 00000100", bus.Redirect_Addr); end
    checks++; if (bus.Pred_Taken !== 1'b0) begin errors++; $display("FAIL alloc_pre_pred got %b exp 0", bus.Pred_Taken); end
    tick();
    drive(32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    checks++; if (bus.Pred_Taken !== 1'b1) begin errors++; $display("FAIL alloc_pred_taken got %b exp 1", bus.Pred_Taken); end
    checks++; if (bus.Pred_Addr !== 32'h100) begin errors++; $display("FAIL alloc_pred_addr got %h exp 00000100", bus.Pred_Addr); end
    checks++; if (bus.Miss_Count !== 16'd1) begin errors++; $display("FAIL alloc_miss_count got %0d exp 1", bus.Miss_Count); end
    checks++; if (bus.Br_Count !== 16'd1) begin errors++; $display("FAIL alloc_br_count got %0d exp 1", bus.Br_Count); end
  endtask

  task automatic test_saturate();
    bit t; logic [31:0] a;
    for (int k = 0; k < 3; k++) begin
      model_lookup(32'h40, t, a);
      drive(32'h40, 1, 32'h40, 0, 32'h0, t, a, 1);
      checks++; if (bus.Mispredict !== (k == 0)) begin errors++; $display("FAIL sat_mispredict_%0d got %b exp %b", k, bus.Mispredict, k == 0); end
      checks++; if (bus.Redirect_Addr !== 32'h44) begin errors++; $display("FAIL sat_redirect_%0d got %h exp 00000044", k, bus.Redirect_Addr); end
      tick();
      drive(32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
      checks++; if (bus.Pred_Taken !== 1'b0 || bus.Pred_Addr !== 32'h44) begin
        errors++; $display("FAIL sat_lookup_%0d got %b/%h exp 0/00000044", k, bus.Pred_Taken, bus.Pred_Addr);
      end
    end
    // One taken from the floor must leave the entry predicting not-taken.
    drive(32'h40, 1, 32'h40, 1, 32'h180, 0, 32'h44, 1);
    tick();
    drive(32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    checks++; if (bus.Pred_Taken !== 1'b0) begin errors++; $display("FAIL sat_floor_hold got %b exp 0", bus.Pred_Taken); end
    checks++; if (bus.Br_Count !== 16'(m_br) || m_br != 5) begin errors++; $display("FAIL sat_br_count got %0d exp 5", bus.Br_Count); end
  endtask

  task automatic test_alias();
    do_reset();
    drive(32'h0, 1, 32'h40, 1, 32'h100, 0, 32'h44, 1); tick();
    drive(32'h0, 1, 32'h80, 1, 32'h200, 0, 32'h84, 1); tick();
    drive(32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    checks++; if (bus.Pred_Taken !== 1'b0 || bus.Pred_Addr !== 32'h44) begin
      errors++; $display("FAIL alias_evicted got %b/%h exp 0/00000044", bus.Pred_Taken, bus.Pred_Addr);
    end
    drive(32'h80, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    checks++; if (bus.Pred_Taken !== 1'b1 || bus.Pred_Addr !== 32'h200) begin
      errors++; $display("FAIL alias_new got %b/%h exp 1/00000200", bus.Pred_Taken, bus.Pred_Addr);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    drive(32'h0, 1, 32'h40, 1, 32'h100, 0, 32'h44, 1); tick();
    drive(32'h40, 1, 32'h40, 1, 32'h300, 1, 32'h100, 1);
    checks++; if (bus.Pred_Taken !== 1'b1 || bus.Pred_Addr !== 32'h100) begin
      errors++; $display("FAIL same_cycle_old got %b/%h exp 1/00000100", bus.Pred_Taken, bus.Pred_Addr);
    end
    checks++; if (bus.Mispredict !== 1'b1) begin errors++; $display("FAIL same_cycle_mis got %b exp 1", bus.Mispredict); end
    tick();
    drive(32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    checks++; if (bus.Pred_Addr !== 32'h300) begin errors++; $display("FAIL same_cycle_new got %h exp 00000300", bus.Pred_Addr); end
    drive(32'h40, 1, 32'h80, 1, 32'h500, 0, 32'h84, 0); tick();
    drive(32'h80, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    checks++; if (bus.Pred_Taken !== 1'b0 || bus.Pred_Addr !== 32'h84) begin
      errors++; $display("FAIL en_low_table got %b/%h exp 0/00000084", bus.Pred_Taken, bus.Pred_Addr);
    end
    checks++; if (bus.Br_Count !== 16'd2 || bus.Miss_Count !== 16'd2) begin
      errors++; $display("FAIL en_low_stats got %0d/%0d exp 2/2", bus.Br_Count, bus.Miss_Count);
    end
    // Asynchronous clear while an update is being presented.
    drive(32'h40, 1, 32'h40, 1, 32'h700, 1, 32'h300, 1);
    #2 CLR_N = 1'b0;
    #1;
    model_reset();
    checks++; if (bus.Pred_Taken !== 1'b0 || bus.Pred_Addr !== 32'h44) begin
      errors++; $display("FAIL async_clr_pred got %b/%h exp 0/00000044", bus.Pred_Taken, bus.Pred_Addr);
    end
    checks++; if (bus.Br_Count !== 16'd0 || bus.Miss_Count !== 16'd0) begin
      errors++; $display("FAIL async_clr_stats got %0d/%0d exp 0/0", bus.Br_Count, bus.Miss_Count);
    end
    @(negedge CLK); bus.Ex_Br = 1'b0;
    @(negedge CLK); CLR_N = 1'b1;
    drive(32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    checks++; if (bus.Pred_Taken !== 1'b0) begin errors++; $display("FAIL async_clr_after got %b exp 0", bus.Pred_Taken); end
  endtask

  task automatic test_random();
    bit t, ptk, tk, br, en, emis; logic [31:0] a, ifpc, expc, tgt, paddr, eredir;
    for (int n = 0; n < 400; n++) begin
      ifpc = 32'(($urandom % 3) * 64 + ($urandom % 4) * 4);
      expc = 32'(($urandom % 3) * 64 + ($urandom % 4) * 4);
      tgt  = 32'(($urandom % 4) * 256 + 32'h1000);
      tk   = ($urandom % 3) != 0;
      br   = ($urandom % 10) < 7;
      en   = ($urandom % 10) != 0;
      model_lookup(expc, ptk, paddr);
      if (($urandom % 4) == 0) begin ptk = $urandom % 2; paddr = tgt; end
      drive(ifpc, br, expc, tk, tgt, ptk, paddr, en);
      model_lookup(ifpc, t, a);
      emis = model_mis(br, tk, ptk, tgt, paddr);
      eredir = tk ? tgt : expc + 32'd4;
      checks++; if (bus.Pred_Taken !== t || bus.Pred_Addr !== a) begin
        errors++; $display("FAIL rand_pred n=%0d pc=%h got %b/%h exp %b/%h", n, ifpc, bus.Pred_Taken, bus.Pred_Addr, t, a);
      end
      checks++; if (bus.Mispredict !== emis || (br && bus.Redirect_Addr !== eredir)) begin
        errors++; $display("FAIL rand_ex n=%0d got %b/%h exp %b/%h", n, bus.Mispredict, bus.Redirect_Addr, emis, eredir);
      end
      tick();
      checks++; if (bus.Br_Count !== 16'(m_br) || bus.Miss_Count !== 16'(m_miss)) begin
        errors++; $display("FAIL rand_stats n=%0d got %0d/%0d exp %0d/%0d", n, bus.Br_Count, bus.Miss_Count, m_br, m_miss);
      end
    end
    drive(32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
  endtask

  task automatic test_static();
    int s_br = 0, s_miss = 0;
    for (int n = 0; n < 261; n++) begin
      @(negedge CLK);
      EN = 1'b1;
      bus2.If_Pc = 32'h40; bus2.Ex_Br = 1'b1; bus2.Ex_Pc = 32'h40; bus2.Ex_Taken = 1'b1;
      bus2.Ex_Target = 32'h100; bus2.Ex_Pred_Taken = bus2.Pred_Taken; bus2.Ex_Pred_Addr = bus2.Pred_Addr;
      #1;
      if (n < 6) begin
        checks++; if (bus2.Pred_Taken !== 1'b0 || bus2.Pred_Addr !== 32'h44) begin
          errors++; $display("FAIL static_pred n=%0d got %b/%h exp 0/00000044", n, bus2.Pred_Taken, bus2.Pred_Addr);
        end
        checks++; if (bus2.Mispredict !== 1'b1 || bus2.Redirect_Addr !== 32'h100) begin
          errors++; $display("FAIL static_mis n=%0d got %b/%h exp 1/00000100", n, bus2.Mispredict, bus2.Redirect_Addr);
        end
      end
      @(posedge CLK); #1;
      if (s_br < 255) s_br++;
      if (s_miss < 255) s_miss++;
      checks++; if (bus2.Br_Count !== 8'(s_br) || bus2.Miss_Count !== 8'(s_miss)) begin
        errors++; $display("FAIL static_stats n=%0d got %0d/%0d exp %0d/%0d", n, bus2.Br_Count, bus2.Miss_Count, s_br, s_miss);
      end
    end
    @(negedge CLK); bus2.Ex_Br = 1'b0;
    checks++; if (bus2.Br_Count !== 8'hFF) begin errors++; $display("FAIL static_br_sat got %0d exp 255", bus2.Br_Count); end
  endtask

  initial begin
    CLR_N = 1'b0; EN = 1'b0;
    bus.If_Pc = '0; bus.Ex_Br = 1'b0; bus.Ex_Pc = '0; bus.Ex_Taken = 1'b0;
    bus.Ex_Target = '0; bus.Ex_Pred_Taken = 1'b0; bus.Ex_Pred_Addr = '0;
    bus2.If_Pc = '0; bus2.Ex_Br = 1'b0; bus2.Ex_Pc = '0; bus2.Ex_Taken = 1'b0;
    bus2.Ex_Target = '0; bus2.Ex_Pred_Taken = 1'b0; bus2.Ex_Pred_Addr = '0;
    model_reset();
    test_reset();
    test_allocate();
    test_saturate();
    test_alias();
    test_same_cycle();
    test_random();
    test_static();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
